// File: rtl/shift_out_multi.sv
// shift_out_multi: multi-lane serial shifter for chained 74HC595-style registers.
// LANES words of WIDTH bits are shifted out MSB- or LSB-first on parallel data
// lines sharing one serial clock, then a latch pulse of LATCH_CYCLES is issued.
// Optional macro SHIFT_OUT_OE_EN adds the active-low output enable oe_n_o, which
// keeps the register chain blanked until the first completed transfer.
module shift_out_multi #(
    parameter int unsigned WIDTH        = 48,
    parameter int unsigned LANES        = 1,
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned LATCH_CYCLES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [LANES*WIDTH-1:0] data_i,
    input  logic                   lsb_first_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sclk_o,
    output logic [LANES-1:0]       data_o,
    output logic                   latch_o
`ifdef SHIFT_OUT_OE_EN
    ,
    output logic                   oe_n_o
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StLatch
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             lsb_q, lsb_d;

    // Snapshot is consumed as a shift register; the bit on data_o is always the
    // one that has just left the active end.
    logic [LANES-1:0][WIDTH-1:0] snap_q, snap_d;
    logic [LANES-1:0][WIDTH-1:0] data_lanes, snap_shl, snap_shr;
    logic [LANES-1:0]            first_bit, next_bit;

    logic             sclk_q, sclk_d;
    logic [LANES-1:0] data_q, data_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign data_lanes = data_i;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign snap_shl[g]  = {snap_q[g][WIDTH-2:0], 1'b0};
        assign snap_shr[g]  = {1'b0, snap_q[g][WIDTH-1:1]};
        assign next_bit[g]  = lsb_q ? snap_q[g][1] : snap_q[g][WIDTH-2];
        assign first_bit[g] = lsb_first_i ? data_lanes[g][0] : data_lanes[g][WIDTH-1];
    end

    // Next-state and registered-output logic of the transfer FSM.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        lat_d   = lat_q;
        lsb_d   = lsb_q;
        snap_d  = snap_q;
        sclk_d  = sclk_q;
        data_d  = data_q;
        latch_d = latch_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    snap_d  = data_i;
                    lsb_d   = lsb_first_i;
                    bit_d   = '0;
                    div_d   = '0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    data_d  = first_bit;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StHigh;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StHigh: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == LAST_BIT) begin
                        latch_d = 1'b1;
                        lat_d   = '0;
                        state_d = StLatch;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        sclk_d  = 1'b0;
                        data_d  = next_bit;
                        snap_d  = lsb_q ? snap_shr : snap_shl;
                        state_d = StLow;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StLatch: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = '0;
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            bit_q   <= '0;
            div_q   <= '0;
            lat_q   <= '0;
            lsb_q   <= 1'b0;
            snap_q  <= '0;
            sclk_q  <= 1'b1;
            data_q  <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            lat_q   <= lat_d;
            lsb_q   <= lsb_d;
            snap_q  <= snap_d;
            sclk_q  <= sclk_d;
            data_q  <= data_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sclk_o  = sclk_q;
    assign data_o  = data_q;
    assign latch_o = latch_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

`ifdef SHIFT_OUT_OE_EN
    logic oe_n_q;

    // Output enable: blanked from reset until the first transfer completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oe_n_q <= 1'b1;
        end else if (done_d) begin
            oe_n_q <= 1'b0;
        end
    end

    assign oe_n_o = oe_n_q;
`endif

endmodule

// File: tb/tb_shift_out_multi.sv
// tb_shift_out_multi: directed bench for shift_out_multi with a scoreboard of
// expected data bits per serial clock rise. Two instances: A (CLK_DIV=2,
// LATCH_CYCLES=1) and B (CLK_DIV=1, LATCH_CYCLES=3), both WIDTH=8, LANES=2.
module tb_shift_out_multi;

    localparam int W = 8;
    localparam int L = 2;

    typedef struct {
        logic [L-1:0] bits;
        int           at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic           start_a = 1'b0, start_b = 1'b0;
    logic [L*W-1:0] data_a = '0, data_b = '0;
    logic           lsb_a = 1'b0, lsb_b = 1'b0;
    logic           busy_a, done_a, sclk_a, latch_a;
    logic           busy_b, done_b, sclk_b, latch_b;
    logic [L-1:0]   dout_a, dout_b;
`ifdef SHIFT_OUT_OE_EN
    logic           oe_n_a, oe_n_b;
    logic           oe_exp [2];
`endif

    always #5 clk = ~clk;

    shift_out_multi #(.WIDTH(W), .LANES(L), .CLK_DIV(2), .LATCH_CYCLES(1)) dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_a),
        .data_i     (data_a),
        .lsb_first_i(lsb_a),
        .busy_o     (busy_a),
        .done_o     (done_a),
        .sclk_o     (sclk_a),
        .data_o     (dout_a),
        .latch_o    (latch_a)
`ifdef SHIFT_OUT_OE_EN
        ,
        .oe_n_o     (oe_n_a)
`endif
    );

    shift_out_multi #(.WIDTH(W), .LANES(L), .CLK_DIV(1), .LATCH_CYCLES(3)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start_b),
        .data_i     (data_b),
        .lsb_first_i(lsb_b),
        .busy_o     (busy_b),
        .done_o     (done_b),
        .sclk_o     (sclk_b),
        .data_o     (dout_b),
        .latch_o    (latch_b)
`ifdef SHIFT_OUT_OE_EN
        ,
        .oe_n_o     (oe_n_b)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    exp_t qa[$];
    exp_t qb[$];

    // Expected activity windows in absolute cycle numbers (from > to = empty).
    int           busy_from [2], busy_to [2];
    int           latch_from[2], latch_to[2];
    int           done_at   [2];
    int           t0s       [2];
    logic [L-1:0] last_bits [2];
    logic         prev_sclk [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic clear_windows(input int u);
        latch_from[u] = 1;
        latch_to[u]   = 0;
        done_at[u]    = -1;
    endtask

    // Per-cycle checks of one instance plus scoreboard pop on each sclk rise.
    task automatic mon(input int u, input logic busy, input logic latch, input logic done,
                       input logic sclk, input logic [L-1:0] dat);
        exp_t e;
        int   qs;
        chk($sformatf("busy%0d", u), 32'(busy), 32'(cyc >= busy_from[u] && cyc <= busy_to[u]));
        chk($sformatf("latch%0d", u), 32'(latch),
            32'(cyc >= latch_from[u] && cyc <= latch_to[u]));
        chk($sformatf("done%0d", u), 32'(done), 32'(cyc == done_at[u]));
        qs = (u == 0) ? qa.size() : qb.size();
        if (sclk && !prev_sclk[u] && !rst) begin
            chk($sformatf("rise_expected%0d", u), 32'(qs > 0), 32'd1);
            if (qs > 0) begin
                e = (u == 0) ? qa.pop_front() : qb.pop_front();
                chk($sformatf("rise_data%0d", u), 32'(dat), 32'(e.bits));
                chk($sformatf("rise_cycle%0d", u), cyc, e.at);
                qs--;
            end
        end
        if (cyc == done_at[u]) begin
            chk($sformatf("rises_left%0d", u), qs, 0);
            chk($sformatf("data_hold%0d", u), 32'(dat), 32'(last_bits[u]));
        end
        prev_sclk[u] = sclk;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (mon_on) begin
            mon(0, busy_a, latch_a, done_a, sclk_a, dout_a);
            mon(1, busy_b, latch_b, done_b, sclk_b, dout_b);
`ifdef SHIFT_OUT_OE_EN
            for (int u = 0; u < 2; u++) begin
                if (rst) oe_exp[u] = 1'b1;
                else if (cyc == done_at[u]) oe_exp[u] = 1'b0;
            end
            chk("oe_n0", 32'(oe_n_a), 32'(oe_exp[0]));
            chk("oe_n1", 32'(oe_n_b), 32'(oe_exp[1]));
`endif
        end
    endtask

    task automatic run_until(input int target);
        while (cyc < target) step();
    endtask

    // Drive a start, push the expected bit sequence and timing windows.
    task automatic start_xfer(input int u, input logic [L*W-1:0] d, input logic lsb);
        int   t0, div, lc;
        exp_t e;
        t0  = cyc + 1;
        div = (u == 0) ? 2 : 1;
        lc  = (u == 0) ? 1 : 3;
        for (int i = 0; i < W; i++) begin
            for (int k = 0; k < L; k++) e.bits[k] = lsb ? d[k*W + i] : d[k*W + W - 1 - i];
            e.at = t0 + (2*i + 1) * div;
            if (u == 0) qa.push_back(e);
            else qb.push_back(e);
            last_bits[u] = e.bits;
        end
        t0s[u]        = t0;
        busy_from[u]  = t0;
        busy_to[u]    = t0 + 2*W*div + lc - 1;
        latch_from[u] = t0 + 2*W*div;
        latch_to[u]   = latch_from[u] + lc - 1;
        done_at[u]    = latch_to[u] + 1;
        if (u == 0) begin
            start_a = 1'b1; data_a = d; lsb_a = lsb;
        end else begin
            start_b = 1'b1; data_b = d; lsb_b = lsb;
        end
        step();
        // Inputs move right after the snapshot; the transfer must not care.
        if (u == 0) begin
            start_a = 1'b0; data_a = ~d; lsb_a = ~lsb;
        end else begin
            start_b = 1'b0; data_b = ~d; lsb_b = ~lsb;
        end
    endtask

    initial begin
        int t0;
        for (int u = 0; u < 2; u++) begin
            busy_from[u] = 1;
            busy_to[u]   = 0;
            clear_windows(u);
            prev_sclk[u] = 1'b1;
            last_bits[u] = '0;
`ifdef SHIFT_OUT_OE_EN
            oe_exp[u] = 1'b1;
`endif
        end

        // Reset held for three cycles.
        repeat (3) step();
        chk("rst_sclk", 32'(sclk_a), 32'd1);
        chk("rst_data", 32'(dout_a), 32'd0);
        chk("rst_latch", 32'(latch_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_sclk_b", 32'(sclk_b), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
`ifdef SHIFT_OUT_OE_EN
        chk("rst_oe_n", 32'(oe_n_a), 32'd1);
`endif
        mon_on = 1'b1;
        rst    = 1'b0;
        repeat (2) step();

        // Transfer aborted by reset sampled at edge 13: three rises seen, no latch/done.
        start_xfer(0, 16'hA53C, 1'b0);
        t0 = t0s[0];
        run_until(t0 + 12);
        rst        = 1'b1;
        busy_to[0] = t0 + 12;
        clear_windows(0);
        step();
        chk("abort_left", qa.size(), 5);
        chk("abort_sclk", 32'(sclk_a), 32'd1);
        chk("abort_data", 32'(dout_a), 32'd0);
        qa.delete();
        rst = 1'b0;
        repeat (2) step();

        // Full MSB-first transfer after the abort.
        start_xfer(0, 16'hA53C, 1'b0);
        run_until(done_at[0] + 2);

        // LSB-first transfer.
        start_xfer(0, 16'h8001, 1'b1);
        run_until(done_at[0] + 2);

        // Mid-transfer data change and start pulse at edge 10 are ignored.
        start_xfer(0, 16'h5AC3, 1'b0);
        t0 = t0s[0];
        run_until(t0 + 9);
        data_a  = 16'hFFFF;
        lsb_a   = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        run_until(done_at[0] + 2);

        // Instance B: second start issued in the done cycle.
        start_xfer(1, 16'hC35A, 1'b0);
        run_until(done_at[1]);
        start_xfer(1, 16'h12E7, 1'b1);
        run_until(done_at[1] + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
